seq_byte_packer: RTL and testbench
==================================

Name: seq_byte_packer

Overview:
- Downstream consumer of the three-flip-flop sequence generator's serial output y.
- Packs the serial bit stream into WIDTH-bit words and delivers them on a valid/ready interface through a one-entry holding register.
- In parallel, detects a programmable bit pattern on the raw stream, counts the matches, and reports dropped words with a sticky flag.

Parameters:
- WIDTH, 8: bits per output word.
- MATCH_W, 4: pattern length in bits.
- MATCH_PATTERN, 4'b1011: pattern to detect; the MSB is the oldest bit.
- CNT_W, 8: width of the match counter.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear; priority over all other inputs.
- bit_in  in  1  serial data bit (generator output y).
- bit_valid  in  1  bit_in is sampled on this cycle.
- out_data  out  WIDTH  packed word; the first bit received lands in out_data[WIDTH-1].
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word.
- overflow  out  1  sticky; a completed word was dropped.
- match_pulse  out  1  one-cycle pulse per pattern match.
- match_count  out  CNT_W  saturating count of matches.

Behaviour:
- Reset: while reset=0, all registers clear asynchronously.
  - The following are 0: shift register, bit counter, pattern history, history-fill counter, out_data, out_valid, overflow, match_pulse, match_count.
  - Reset is allowed mid-word; a partial word is discarded.
- Shift path: on bit_valid=1, shift_reg <= {shift_reg[WIDTH-2:0], bit_in} and bit_cnt increments.
  - Cycles with bit_valid=0 hold all shift and pattern state.
- Word complete: bit_valid=1 with bit_cnt==WIDTH-1.
  - The next-word value is {shift_reg[WIDTH-2:0], bit_in}.
  - bit_cnt wraps to 0 unconditionally.
- Output FSM has two states:
  - EMPTY: out_valid=0. On word complete, load out_data and go to FULL. out_valid rises the cycle after the edge that samples the WIDTH-th bit (latency 1).
  - FULL: out_valid=1, and out_data is held stable until accepted.
    - out_ready=1 with no word complete: go to EMPTY.
    - out_ready=1 with word complete on the same edge: load the new word and stay in FULL. There is no bubble and no overflow.
    - out_ready=0 with word complete: keep the old word, drop the new one, and set overflow=1.
- overflow stays set until clear or reset.
- out_valid never drops without a handshake (out_valid & out_ready), except on clear or reset.
- Pattern detector:
  - hist is MATCH_W bits; it shifts on every bit_valid, independent of word boundaries.
  - fill counts received bits and saturates at MATCH_W.
  - A match is {hist[MATCH_W-2:0], bit_in}==MATCH_PATTERN with (fill>=MATCH_W-1) on a bit_valid cycle.
  - match_pulse is registered: it is high the cycle after the completing bit.
  - Overlapping matches each count.
  - match_count increments with each match and saturates at 2^CNT_W-1 (no wrap).
- clear=1 at an edge:
  - Zeroes bit_cnt, shift_reg, hist, fill, overflow, match_count, match_pulse and out_valid.
  - Discards any held word.
  - The bit presented on that cycle is ignored.
- Simultaneous clear and reset: reset wins (asynchronous).

Test Plan:
1. MSB-first packing: out_ready=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> one cycle after the 8th bit, out_valid=1 and out_data=8'hB2; after the handshake, out_valid=0; overflow=0.
2. Overlapping match: stream 1,0,1,1,0,1,1 -> match_pulse high after the 4th and 7th bits; match_count=2.
   - Gap variant: repeat with bit_valid=0 gaps between bits -> same result.
3. Back-pressure: out_ready=0, send 16 bits (0xA5, then 0x3C) -> out_data stays 8'hA5 with out_valid=1, overflow=1. Then raise out_ready -> 0xA5 is accepted; out_valid=0; overflow remains 1.
4. Simultaneous drain and load: FULL with 0x11, out_ready=1 on the cycle the 8th bit of 0x22 is sampled -> next cycle out_valid=1, out_data=8'h22, overflow=0.
5. Mid-word reset/clear: send 5 bits, pulse reset=0, then send 8 bits of 0xC3 -> out_data=8'hC3.
   - Clear variant: repeat with clear instead of reset -> same result; match_count=0 after clear.
6. Saturation: CNT_W=2, stream 1011 repeated 5 times (5+ matches) -> match_count stops at 3; match_pulse still fires per match.

Source files
------------

// File: rtl/seq_byte_packer.sv
// Serial-to-parallel word packer with a one-entry valid/ready holding register,
// plus a programmable bit-pattern detector with a saturating match counter.
module seq_byte_packer #(
  parameter int unsigned        WIDTH         = 8,
  parameter int unsigned        MATCH_W       = 4,
  parameter logic [MATCH_W-1:0] MATCH_PATTERN = 4'b1011,
  parameter int unsigned        CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned BC_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned FILL_W = $clog2(MATCH_W + 1);

  localparam logic [BC_W-1:0]   LAST_BIT = BC_W'(WIDTH - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MATCH_W);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(MATCH_W - 1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // The oldest bit of each shifter is never observed, so only W-1 bits are stored.
  logic [WIDTH-2:0]   shift_reg;
  logic [BC_W-1:0]    bit_cnt;
  logic [MATCH_W-2:0] hist;
  logic [FILL_W-1:0]  fill;

  logic               word_done_c;
  logic [WIDTH-1:0]   next_word_c;
  logic [MATCH_W-1:0] hist_next_c;
  logic               match_c;
  logic               load_c;
  logic               drop_c;

  always_comb begin
    next_word_c = {shift_reg, bit_in};
    hist_next_c = {hist, bit_in};
    word_done_c = bit_valid && (bit_cnt == LAST_BIT);
    match_c     = bit_valid && (fill >= FILL_ARM) && (hist_next_c == MATCH_PATTERN);
  end

  // Shift path: word assembly and bit position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (clear) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (bit_valid) begin
      shift_reg <= next_word_c[WIDTH-2:0];
      bit_cnt   <= word_done_c ? '0 : bit_cnt + BC_W'(1);
    end
  end

  // Pattern history runs on every accepted bit, independent of word boundaries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (bit_valid) begin
      hist <= hist_next_c[MATCH_W-2:0];
      if (fill != FILL_MAX) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_pulse <= 1'b0;
      match_count <= '0;
    end else if (clear) begin
      match_pulse <= 1'b0;
      match_count <= '0;
    end else begin
      match_pulse <= match_c;
      if (match_c && (match_count != {CNT_W{1'b1}})) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (word_done_c) state_next = S_FULL;
        S_FULL:  if (out_ready && !word_done_c) state_next = S_EMPTY;
        default: state_next = S_EMPTY;
      endcase
    end
  end

  // A completed word loads when the slot is free or drains on the same edge.
  always_comb begin
    load_c = 1'b0;
    drop_c = 1'b0;
    if (!clear && word_done_c) begin
      if ((state == S_EMPTY) || out_ready) begin
        load_c = 1'b1;
      end else begin
        drop_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data <= '0;
    end else if (load_c) begin
      out_data <= next_word_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (drop_c) begin
      overflow <= 1'b1;
    end
  end

  assign out_valid = (state == S_FULL);

endmodule

// File: tb/tb_seq_byte_packer.sv
// Bench for seq_byte_packer: directed scenarios plus random traffic, checked
// against a word/pattern scoreboard; a CNT_W=2 instance covers counter saturation.
module tb_seq_byte_packer;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       bit_in;
  logic       bit_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       overflow;
  logic       match_pulse;
  logic [7:0] match_count;
  logic [7:0] out_data2;
  logic       out_valid2;
  logic       overflow2;
  logic       match_pulse2;
  logic [1:0] match_count2;

  seq_byte_packer dut (
    .clk(clk), .reset(reset), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .match_pulse(match_pulse), .match_count(match_count)
  );

  seq_byte_packer #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .overflow(overflow2), .match_pulse(match_pulse2), .match_count(match_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: bits-in-current-word, accumulated value, holding slot, last bits seen.
  int m_nbits, m_word, m_full, m_data, m_ovf, m_pulse, m_cnt8, m_cnt2;
  int hist[$];

  function automatic void model_zero();
    m_nbits = 0; m_word = 0; m_full = 0; m_data = 0;
    m_ovf = 0; m_pulse = 0; m_cnt8 = 0; m_cnt2 = 0;
    hist.delete();
  endfunction

  function automatic int hist_val();
    int v = 0;
    foreach (hist[i]) v = v * 2 + hist[i];
    return v;
  endfunction

  function automatic void model_step(input bit b, input bit v, input bit r, input bit c);
    bit done = 1'b0;
    if (c) begin
      m_nbits = 0; m_word = 0; m_full = 0; m_ovf = 0;
      m_pulse = 0; m_cnt8 = 0; m_cnt2 = 0;
      hist.delete();
      return;
    end
    m_pulse = 0;
    if (v) begin
      m_word = ((m_word * 2) + int'(b)) % 256;
      m_nbits++;
      if (m_nbits == 8) begin
        done = 1'b1;
        m_nbits = 0;
      end
      hist.push_back(int'(b));
      if (hist.size() > 4) void'(hist.pop_front());
      if (hist.size() == 4 && hist_val() == 11) begin
        m_pulse = 1;
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
    end
    if (m_full != 0 && r) m_full = 0;
    if (done) begin
      if (m_full == 0) begin
        m_full = 1;
        m_data = m_word;
      end else begin
        m_ovf = 1;
      end
    end
  endfunction

  task automatic check_all();
    check("out_valid", out_valid, m_full);
    if (m_full != 0) check("out_data", out_data, m_data);
    check("overflow", overflow, m_ovf);
    check("match_pulse", match_pulse, m_pulse);
    check("match_count", match_count, m_cnt8);
    check("sat_out_valid", out_valid2, m_full);
    check("sat_match_pulse", match_pulse2, m_pulse);
    check("sat_match_count", match_count2, m_cnt2);
  endtask

  // Drives at the falling edge, models the rising edge, samples at the next falling edge.
  task automatic cycle(input bit b, input bit v, input bit r, input bit c);
    bit_in = b; bit_valid = v; out_ready = r; clear = c;
    @(posedge clk);
    model_step(b, v, r, c);
    @(negedge clk);
    check_all();
  endtask

  task automatic send_byte(input int val, input bit r);
    for (int i = 7; i >= 0; i--) cycle(1'((val >> i) & 1), 1'b1, r, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_zero();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_match_pulse", match_pulse, 0);
    check("rst_match_count", match_count, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int pmask;
    int pcnt;
    int bits7;
    reset = 1'b0; clear = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
    model_zero();
    do_reset();

    // MSB-first packing
    send_byte(8'hB2, 1'b1);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 8'hB2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_drained", out_valid, 0);
    check("t1_overflow", overflow, 0);

    // Overlapping match, back-to-back then with gaps
    bits7 = 7'b1011011;
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    pmask = 0;
    for (int i = 6; i >= 0; i--) begin
      cycle(1'((bits7 >> i) & 1), 1'b1, 1'b1, 1'b0);
      pmask = pmask * 2 + int'(match_pulse);
    end
    check("t2_pulses", pmask, 7'b0001001);
    check("t2_count", match_count, 2);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    pmask = 0;
    for (int i = 6; i >= 0; i--) begin
      cycle(1'((bits7 >> i) & 1), 1'b1, 1'b1, 1'b0);
      pmask = pmask * 2 + int'(match_pulse);
      for (int g = $urandom_range(2, 0); g > 0; g--) cycle(1'($urandom), 1'b0, 1'b1, 1'b0);
    end
    check("t2g_pulses", pmask, 7'b0001001);
    check("t2g_count", match_count, 2);

    // Back-pressure with a dropped second word
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    check("t3_data", out_data, 8'hA5);
    check("t3_valid", out_valid, 1);
    check("t3_overflow", overflow, 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_drained", out_valid, 0);
    check("t3_sticky", overflow, 1);

    // Drain and load on the same edge
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_byte(8'h11, 1'b0);
    for (int i = 7; i >= 0; i--) cycle(1'((8'h22 >> i) & 1), 1'b1, (i == 0), 1'b0);
    check("t4_valid", out_valid, 1);
    check("t4_data", out_data, 8'h22);
    check("t4_overflow", overflow, 0);

    // Mid-word reset, then mid-word clear
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'($urandom), 1'b1, 1'b0, 1'b0);
    do_reset();
    send_byte(8'hC3, 1'b0);
    check("t5_data", out_data, 8'hC3);
    for (int i = 0; i < 5; i++) cycle(1'($urandom), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("t5c_count", match_count, 0);
    check("t5c_valid", out_valid, 0);
    send_byte(8'hC3, 1'b0);
    check("t5c_data", out_data, 8'hC3);

    // Counter saturation on the narrow instance
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    pcnt = 0;
    for (int k = 0; k < 5; k++) begin
      for (int i = 3; i >= 0; i--) begin
        cycle(1'((4'b1011 >> i) & 1), 1'b1, 1'b1, 1'b0);
        pcnt += int'(match_pulse2);
      end
    end
    check("t6_sat_count", match_count2, 3);
    check("t6_sat_pulses", pcnt, 5);
    check("t6_wide_count", match_count, 5);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(399, 0) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom), ($urandom_range(3, 0) != 0), 1'($urandom),
              ($urandom_range(49, 0) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
